// File: rtl/gated_rr_seq.sv
// N-channel grant sequencer: round-robin, fixed-priority or broadcast arbitration with fixed-width grants.
// Optional completed-grant counter is built when GATED_RR_SEQ_GCNT_EN is defined.
module gated_rr_seq #(
    parameter int NCH      = 8,
    parameter int HOLD_CYC = 3,
    parameter int CNT_W    = 8
) (
    input  logic                     CK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic [1:0]               MODE,
    input  logic [NCH-1:0]           REQ,
    input  logic [NCH-1:0]           GATE,
    output logic [NCH-1:0]           OUT,
    output logic [NCH-1:0]           OUTBF,
    output logic [$clog2(NCH)-1:0]   PTR,
    output logic                     BUSY,
    output logic                     ERR,
    output logic [CNT_W-1:0]         GCNT
);

    localparam int PW = $clog2(NCH);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t         state;
    logic [NCH-1:0] gnt;
    logic [HW-1:0]  hold;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  win;
    logic           rrmode;
    logic           err;

    logic           rrfound;
    logic [PW-1:0]  rridx;
    logic [PW-1:0]  pridx;
    logic [NCH-1:0] nextgnt;

    // Round-robin search starts at ptr and wraps modulo NCH, so NCH need not be a power of two.
    always_comb begin
        int j;
        rrfound = 1'b0;
        rridx   = '0;
        j       = 0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr) + k;
            if (j >= NCH) j = j - NCH;
            if (!rrfound && REQ[j]) begin
                rrfound = 1'b1;
                rridx   = PW'(j);
            end
        end
    end

    always_comb begin
        pridx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (REQ[k]) pridx = PW'(k);
        end
    end

    always_comb begin
        case (MODE)
            2'd0:    nextgnt = NCH'(1) << rridx;
            2'd1:    nextgnt = NCH'(1) << pridx;
            default: nextgnt = REQ;
        endcase
    end

    // The arbitration mode and winner are captured at grant time, so later MODE changes cannot affect PTR.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            gnt    <= '0;
            hold   <= '0;
            ptr    <= '0;
            win    <= '0;
            rrmode <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (EN) begin
                        if (MODE == 2'd3) begin
                            err <= 1'b1;
                        end else if (|REQ) begin
                            gnt    <= nextgnt;
                            hold   <= HW'(HOLD_CYC - 1);
                            rrmode <= (MODE == 2'd0);
                            win    <= rridx;
                            state  <= GRANT;
                        end
                    end
                end
                GRANT: begin
                    if (!EN) begin
                        gnt   <= '0;
                        state <= GAP;
                    end else if (hold != '0) begin
                        hold <= hold - HW'(1);
                    end else begin
                        gnt   <= '0;
                        state <= GAP;
                        if (rrmode) begin
                            if (win == PW'(NCH - 1)) ptr <= '0;
                            else                     ptr <= win + PW'(1);
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GATED_RR_SEQ_GCNT_EN
    logic             done;
    logic [CNT_W-1:0] gcnt;

    assign done = (state == GRANT) && EN && (hold == '0);

    // Saturating count of grants that ran their full width; aborted grants are not counted.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            gcnt <= '0;
        end else if (done && (gcnt != '1)) begin
            gcnt <= gcnt + CNT_W'(1);
        end
    end

    assign GCNT = gcnt;
`else
    assign GCNT = '0;
`endif

    assign OUT   = gnt & GATE;
    assign OUTBF = ~OUT;
    assign PTR   = ptr;
    assign BUSY  = (state == GRANT);
    assign ERR   = err;

endmodule

// File: tb/tb_gated_rr_seq.sv
// Directed scoreboard bench for gated_rr_seq (NCH=8, HOLD_CYC=3, CNT_W=8).
// Expected GCNT follows GATED_RR_SEQ_GCNT_EN the same way the design does.
module tb_gated_rr_seq;

    logic       ck;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] req;
    logic [7:0] gate;
    logic [7:0] outv;
    logic [7:0] outbf;
    logic [2:0] ptr;
    logic       busy;
    logic       err;
    logic [7:0] gcnt;

    typedef struct {
        logic [7:0] out;
        logic       busy;
        logic [2:0] ptr;
        logic       err;
        logic [7:0] gcnt;
    } expT;

    expT        sbq[$];
    int         nAsserts = 0;
    int         nFail    = 0;
    logic [7:0] gc       = 8'h00;

    gated_rr_seq #(
        .NCH(8),
        .HOLD_CYC(3),
        .CNT_W(8)
    ) dut (
        .CK(ck),
        .RST(rst),
        .EN(en),
        .MODE(mode),
        .REQ(req),
        .GATE(gate),
        .OUT(outv),
        .OUTBF(outbf),
        .PTR(ptr),
        .BUSY(busy),
        .ERR(err),
        .GCNT(gcnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [7:0] gx();
`ifdef GATED_RR_SEQ_GCNT_EN
        return gc;
`else
        return 8'h00;
`endif
    endfunction

    task automatic bump();
        if (gc != 8'hFF) gc = gc + 8'h01;
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [7:0] r, input logic [7:0] g);
        en   = e;
        mode = m;
        req  = r;
        gate = g;
    endtask

    task automatic expectOut(input int n, input logic [7:0] o, input logic b, input logic [2:0] p, input logic er);
        expT e;
        e.out  = o;
        e.busy = b;
        e.ptr  = p;
        e.err  = er;
        e.gcnt = gx();
        for (int i = 0; i < n; i++) sbq.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        expT e;
        if (sbq.size() == 0) begin
            nAsserts++;
            nFail++;
            $error("[TB] FAIL %s scoreboard empty observed out=%h", tag, outv);
        end else begin
            e = sbq.pop_front();
            nAsserts++;
            assert (outv === e.out) else begin
                nFail++;
                $error("[TB] FAIL %s OUT observed=%h expected=%h", tag, outv, e.out);
            end
            nAsserts++;
            assert (outbf === ~e.out) else begin
                nFail++;
                $error("[TB] FAIL %s OUTBF observed=%h expected=%h", tag, outbf, ~e.out);
            end
            nAsserts++;
            assert (busy === e.busy) else begin
                nFail++;
                $error("[TB] FAIL %s BUSY observed=%b expected=%b", tag, busy, e.busy);
            end
            nAsserts++;
            assert (ptr === e.ptr) else begin
                nFail++;
                $error("[TB] FAIL %s PTR observed=%0d expected=%0d", tag, ptr, e.ptr);
            end
            nAsserts++;
            assert (err === e.err) else begin
                nFail++;
                $error("[TB] FAIL %s ERR observed=%b expected=%b", tag, err, e.err);
            end
            nAsserts++;
            assert (gcnt === e.gcnt) else begin
                nFail++;
                $error("[TB] FAIL %s GCNT observed=%0d expected=%0d", tag, gcnt, e.gcnt);
            end
        end
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge ck);
            #1;
            checkOutput(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h00, 8'h00);
        #7;
        expectOut(1, 8'h00, 1'b0, 3'd0, 1'b0);
        checkOutput("reset");
        #1;
        rst = 1'b0;

        // Round-robin from PTR=0: bit2, then bit7 with wrap, then bit2 again
        applyStimulus(1'b1, 2'd0, 8'h84, 8'hFF);
        expectOut(3, 8'h04, 1'b1, 3'd0, 1'b0);
        runCycles(3, "rr_first");
        bump();
        expectOut(2, 8'h00, 1'b0, 3'd3, 1'b0);
        runCycles(2, "rr_gap1");
        expectOut(3, 8'h80, 1'b1, 3'd3, 1'b0);
        runCycles(3, "rr_second");
        bump();
        expectOut(2, 8'h00, 1'b0, 3'd0, 1'b0);
        runCycles(2, "ptr_wrap");
        expectOut(3, 8'h04, 1'b1, 3'd0, 1'b0);
        runCycles(3, "rr_third");
        bump();
        expectOut(1, 8'h00, 1'b0, 3'd3, 1'b0);
        runCycles(1, "rr_gap3");

        // Move PTR to 6 by granting bit5 in round-robin
        applyStimulus(1'b1, 2'd0, 8'h20, 8'hFF);
        expectOut(1, 8'h00, 1'b0, 3'd3, 1'b0);
        runCycles(1, "idle_a");
        expectOut(3, 8'h20, 1'b1, 3'd3, 1'b0);
        runCycles(3, "rr_bit5");
        bump();
        expectOut(1, 8'h00, 1'b0, 3'd6, 1'b0);
        runCycles(1, "ptr_six");

        // Fixed priority with PTR=6: lowest set bit wins, PTR untouched
        applyStimulus(1'b1, 2'd1, 8'hA0, 8'hFF);
        expectOut(1, 8'h00, 1'b0, 3'd6, 1'b0);
        runCycles(1, "idle_b");
        expectOut(3, 8'h20, 1'b1, 3'd6, 1'b0);
        runCycles(3, "prio");
        bump();
        expectOut(1, 8'h00, 1'b0, 3'd6, 1'b0);
        runCycles(1, "prio_ptr");

        // Broadcast, then REQ/MODE/GATE changes while granted
        applyStimulus(1'b1, 2'd2, 8'hA5, 8'h0F);
        expectOut(1, 8'h00, 1'b0, 3'd6, 1'b0);
        runCycles(1, "idle_c");
        expectOut(1, 8'h05, 1'b1, 3'd6, 1'b0);
        runCycles(1, "bcast");
        applyStimulus(1'b1, 2'd1, 8'h00, 8'h0F);
        expectOut(1, 8'h05, 1'b1, 3'd6, 1'b0);
        runCycles(1, "bcast_hold");
        applyStimulus(1'b1, 2'd1, 8'h00, 8'h03);
        expectOut(1, 8'h01, 1'b1, 3'd6, 1'b0);
        runCycles(1, "gate_mask");
        bump();
        expectOut(1, 8'h00, 1'b0, 3'd6, 1'b0);
        runCycles(1, "bcast_done");

        // Abort in the second grant cycle: not counted, PTR unchanged
        applyStimulus(1'b1, 2'd0, 8'h84, 8'hFF);
        expectOut(1, 8'h00, 1'b0, 3'd6, 1'b0);
        runCycles(1, "idle_d");
        expectOut(2, 8'h80, 1'b1, 3'd6, 1'b0);
        runCycles(2, "abort_pre");
        applyStimulus(1'b0, 2'd0, 8'h84, 8'hFF);
        expectOut(2, 8'h00, 1'b0, 3'd6, 1'b0);
        runCycles(2, "abort");

        // Illegal mode sets a sticky error
        applyStimulus(1'b1, 2'd3, 8'hFF, 8'hFF);
        expectOut(2, 8'h00, 1'b0, 3'd6, 1'b1);
        runCycles(2, "illegal");
        applyStimulus(1'b1, 2'd0, 8'hFF, 8'hFF);
        expectOut(3, 8'h40, 1'b1, 3'd6, 1'b1);
        runCycles(3, "err_sticky");
        bump();
        expectOut(2, 8'h00, 1'b0, 3'd7, 1'b1);
        runCycles(2, "rr_ptr7");
        expectOut(1, 8'h80, 1'b1, 3'd7, 1'b1);
        runCycles(1, "pre_rst");

        // Asynchronous reset between edges in the middle of a grant
        #2;
        rst = 1'b1;
        #1;
        gc = 8'h00;
        expectOut(1, 8'h00, 1'b0, 3'd0, 1'b0);
        checkOutput("rst_async");
        #2;
        rst = 1'b0;
`ifdef GATED_RR_SEQ_GCNT_EN
        force dut.gcnt = 8'hFF;
        #1;
        release dut.gcnt;
        gc = 8'hFF;
`endif
        expectOut(3, 8'h01, 1'b1, 3'd0, 1'b0);
        runCycles(3, "post_rst");
        bump();
        expectOut(1, 8'h00, 1'b0, 3'd1, 1'b0);
        runCycles(1, "gcnt_sat");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
